// File: rtl/srt_result_unload.sv
// ----------------------------------------------------------------------------
// srt_result_unload
//   Read side of the SRT divider datapath. On the divider's done pulse it
//   captures the redundant quotient (q_pos/q_neg), the partial remainder and
//   the divisor. It then converts the quotient to binary, applies the SRT
//   final correction, and presents quotient/remainder on a valid/ready
//   handshake.
//
//   Optional feature macro: SRT_UNLOAD_EXACT_EN
//     When defined, adds output 'exact', which is high when the corrected
//     remainder is zero. It is loaded together with the result.
//
// Ports
//   clk        in   1      rising-edge clock
//   resetn     in   1      asynchronous active-low reset
//   done       in   1      one-cycle pulse: divider registers are final
//   q_pos      in   WIDTH  positive-digit quotient register
//   q_neg      in   WIDTH  negative-digit quotient register
//   rem_in     in   WIDTH  partial remainder, two's complement
//   divisor    in   WIDTH  divisor, unsigned
//   out_ready  in   1      consumer accepts result
//   out_valid  out  1      result held on quotient/remainder
//   quotient   out  WIDTH  corrected binary quotient
//   remainder  out  WIDTH  corrected non-negative remainder
//   busy       out  1      state != IDLE (registered)
//   overrun    out  1      sticky: done arrived when it could not be taken
//   exact      out  1      (SRT_UNLOAD_EXACT_EN only) remainder == 0
// ----------------------------------------------------------------------------
module srt_result_unload #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             done,
  input  logic [WIDTH-1:0] q_pos,
  input  logic [WIDTH-1:0] q_neg,
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             overrun
`ifdef SRT_UNLOAD_EXACT_EN
  ,
  output logic             exact
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAPT = 3'd1,
    S_CONV = 3'd2,
    S_FIX  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] qp_q;
  logic [WIDTH-1:0] qn_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             overrun_q;
`ifdef SRT_UNLOAD_EXACT_EN
  logic             exact_q;
`endif

  // A new operand set is accepted from IDLE, or from OUT on the same edge
  // the current result is handed over (back-to-back operation).
  logic capture_d;
  logic handshake_d;
  logic overrun_d;
  assign handshake_d = (state_q == S_OUT) && out_ready;
  assign capture_d   = done && ((state_q == S_IDLE) || handshake_d);
  // Any other done while busy is dropped and flagged.
  assign overrun_d   = done && (state_q != S_IDLE) && !capture_d;

  // SRT final correction: a negative partial remainder means the quotient
  // overshot by one; step it back and restore the remainder.
  logic             rem_neg_d;
  logic [WIDTH-1:0] q_fix_d;
  logic [WIDTH-1:0] rem_fix_d;
  assign rem_neg_d = rem_q[WIDTH-1];
  assign q_fix_d   = rem_neg_d ? (q_q - WIDTH'(1)) : q_q;
  assign rem_fix_d = rem_neg_d ? (rem_q + div_q) : rem_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      qp_q        <= '0;
      qn_q        <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SRT_UNLOAD_EXACT_EN
      exact_q     <= 1'b0;
`endif
    end else begin
      if (overrun_d) begin
        overrun_q <= 1'b1;
      end

      if (capture_d) begin
        qp_q  <= q_pos;
        qn_q  <= q_neg;
        rem_q <= rem_in;
        div_q <= divisor;
      end

      case (state_q)
        S_IDLE: begin
          if (capture_d) begin
            state_q <= S_CAPT;
            busy_q  <= 1'b1;
          end
        end
        S_CAPT: begin
          q_q     <= qp_q - qn_q;
          state_q <= S_CONV;
        end
        S_CONV: begin
          // Always spent, correction or not, so latency is fixed.
          q_q     <= q_fix_d;
          rem_q   <= rem_fix_d;
          state_q <= S_FIX;
        end
        S_FIX: begin
          quotient_q  <= q_q;
          remainder_q <= rem_q;
`ifdef SRT_UNLOAD_EXACT_EN
          exact_q     <= (rem_q == '0);
`endif
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (handshake_d) begin
            out_valid_q <= 1'b0;
            if (capture_d) begin
              state_q <= S_CAPT;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
`ifdef SRT_UNLOAD_EXACT_EN
  assign exact     = exact_q;
`endif

endmodule

// File: tb/tb_srt_result_unload.sv
// ----------------------------------------------------------------------------
// tb_srt_result_unload
//   Directed and randomized checks for srt_result_unload. Expected results
//   come from plain arithmetic on the operands (binary quotient is
//   q_pos - q_neg, minus one with the remainder restored by the divisor when
//   the remainder is negative).
// ----------------------------------------------------------------------------
module tb_srt_result_unload;

  localparam int W = 26;

  logic         clk;
  logic         resetn;
  logic         done;
  logic [W-1:0] q_pos;
  logic [W-1:0] q_neg;
  logic [W-1:0] rem_in;
  logic [W-1:0] divisor;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         overrun;
`ifdef SRT_UNLOAD_EXACT_EN
  logic         exact;
`endif

  int checks;
  int failures;

  srt_result_unload #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .done      (done),
    .q_pos     (q_pos),
    .q_neg     (q_neg),
    .rem_in    (rem_in),
    .divisor   (divisor),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SRT_UNLOAD_EXACT_EN
    ,
    .exact     (exact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_q(input logic [W-1:0] qp, input logic [W-1:0] qn,
                                           input logic [W-1:0] r);
    int unsigned v;
    v = int'(qp) - int'(qn) - (r[W-1] ? 1 : 0);
    return W'(v);
  endfunction

  function automatic logic [W-1:0] model_r(input logic [W-1:0] r, input logic [W-1:0] d);
    int unsigned v;
    v = int'(r) + (r[W-1] ? int'(d) : 0);
    return W'(v);
  endfunction

  task automatic apply_done(input logic [W-1:0] qp, input logic [W-1:0] qn,
                            input logic [W-1:0] r, input logic [W-1:0] d);
    q_pos = qp; q_neg = qn; rem_in = r; divisor = d; done = 1'b1;
  endtask

  task automatic scramble_inputs();
    done    = 1'b0;
    q_pos   = W'($urandom);
    q_neg   = W'($urandom);
    rem_in  = W'($urandom);
    divisor = W'($urandom);
  endtask

  // Full transaction from IDLE: done pulse, wait (bounded) for out_valid,
  // check latency/result, hold for 'delay' cycles with out_ready low.
  task automatic run_txn(input string tag, input logic [W-1:0] qp, input logic [W-1:0] qn,
                         input logic [W-1:0] r, input logic [W-1:0] d, input int delay);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int n;
    eq = model_q(qp, qn, r);
    er = model_r(r, d);
    out_ready = (delay == 0);
    apply_done(qp, qn, r, d);
    step();
    scramble_inputs();
    n = 1;
    while (!out_valid && n < 8) begin
      step();
      n++;
    end
    check({tag, ".latency"}, n, 4);
    check({tag, ".valid"}, {31'd0, out_valid}, 1);
    check({tag, ".quotient"}, {6'd0, quotient}, {6'd0, eq});
    check({tag, ".remainder"}, {6'd0, remainder}, {6'd0, er});
    for (int i = 0; i < delay; i++) begin
      step();
      check({tag, ".hold_valid"}, {31'd0, out_valid}, 1);
      check({tag, ".hold_q"}, {6'd0, quotient}, {6'd0, eq});
      check({tag, ".hold_r"}, {6'd0, remainder}, {6'd0, er});
    end
    out_ready = 1'b1;
    step();
    check({tag, ".valid_drop"}, {31'd0, out_valid}, 0);
    check({tag, ".idle"}, {31'd0, busy}, 0);
    check({tag, ".q_kept"}, {6'd0, quotient}, {6'd0, eq});
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done = 1'b0; out_ready = 1'b0;
    q_pos = '0; q_neg = '0; rem_in = '0; divisor = '0;
    resetn = 1'b0;
    #12;
    check("reset.valid", {31'd0, out_valid}, 0);
    check("reset.busy", {31'd0, busy}, 0);
    check("reset.overrun", {31'd0, overrun}, 0);
    check("reset.quotient", {6'd0, quotient}, 0);
    check("reset.remainder", {6'd0, remainder}, 0);
    resetn = 1'b1;
    step();

    // T1 / T2 / T3
    run_txn("T1", W'(20), W'(5), W'(3), W'(7), 0);
    run_txn("T2", W'(20), W'(4), 26'h3FFFFFE, W'(7), 0);
    run_txn("T3", W'(20), W'(5), W'(3), W'(7), 5);

    // T4a: done while in CONV is dropped and flagged
    out_ready = 1'b1;
    apply_done(W'(20), W'(5), W'(3), W'(7));
    step();                                  // edge1 -> CAPT
    done = 1'b0;
    step();                                  // edge2 -> CONV
    apply_done(W'(100), W'(1), W'(0), W'(9));
    step();                                  // edge3, done in CONV
    done = 1'b0;
    check("T4.overrun", {31'd0, overrun}, 1);
    step();                                  // edge4 -> OUT
    check("T4.valid", {31'd0, out_valid}, 1);
    check("T4.quotient", {6'd0, quotient}, 15);
    check("T4.remainder", {6'd0, remainder}, 3);
    step();
    check("T4.no_second_valid", {31'd0, out_valid}, 0);
    for (int i = 0; i < 5; i++) step();
    check("T4.no_second_busy", {31'd0, busy}, 0);
    check("T4.no_second_valid_late", {31'd0, out_valid}, 0);

    // T4b: done coincident with handshake -> back-to-back result
    do_reset();
    out_ready = 1'b0;
    apply_done(W'(20), W'(5), W'(3), W'(7));
    step();
    done = 1'b0;
    step(); step(); step();
    check("T4b.valid1", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    apply_done(W'(50), W'(8), 26'h3FFFFFF, W'(11));
    step();                                  // handshake + capture edge
    done = 1'b0;
    out_ready = 1'b0;
    check("T4b.drop", {31'd0, out_valid}, 0);
    check("T4b.busy", {31'd0, busy}, 1);
    step(); step();
    check("T4b.not_yet", {31'd0, out_valid}, 0);
    step();
    check("T4b.valid2", {31'd0, out_valid}, 1);
    check("T4b.quotient2", {6'd0, quotient}, {6'd0, model_q(W'(50), W'(8), 26'h3FFFFFF)});
    check("T4b.remainder2", {6'd0, remainder}, {6'd0, model_r(26'h3FFFFFF, W'(11))});
    check("T4b.no_overrun", {31'd0, overrun}, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // T5: asynchronous reset while in FIX
    apply_done(W'(20), W'(5), W'(3), W'(7));
    step();
    done = 1'b0;
    step(); step();                          // now in FIX
    check("T5.busy_pre", {31'd0, busy}, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("T5.valid", {31'd0, out_valid}, 0);
    check("T5.busy", {31'd0, busy}, 0);
    check("T5.quotient", {6'd0, quotient}, 0);
    check("T5.remainder", {6'd0, remainder}, 0);
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("T5.no_spurious", {31'd0, out_valid | busy}, 0);
    end

`ifdef SRT_UNLOAD_EXACT_EN
    // T6
    run_txn("T6a", W'(14), W'(0), W'(0), W'(7), 0);
    check("T6a.exact", {31'd0, exact}, 1);
    run_txn("T6b", W'(14), W'(0), W'(3), W'(7), 0);
    check("T6b.exact", {31'd0, exact}, 0);
`endif

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] rq;
      logic [W-1:0] rn;
      logic [W-1:0] rr;
      logic [W-1:0] rd;
      rq = W'($urandom);
      rn = W'($urandom);
      rr = W'($urandom);
      rd = W'($urandom);
      run_txn($sformatf("R%0d", t), rq, rn, rr, rd, int'($urandom_range(0, 3)));
      $display("txn R%0d q_pos=%h q_neg=%h rem=%h div=%h -> q=%h r=%h",
               t, rq, rn, rr, rd, quotient, remainder);
    end
    check("final.overrun", {31'd0, overrun}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
